// File: rtl/axis_hdr_pkg.sv
// Shared FSM type, default geometry and keep/byte-count helpers for the multi-beat header inserter.
package axis_hdr_pkg;

    localparam int DEF_DATA_WD    = 32;
    localparam int DEF_DATA_BYTES = DEF_DATA_WD / 8;
    localparam int DEF_HDR_BYTES  = 12;
    localparam int RES_CNT_WD     = $clog2(DEF_DATA_BYTES);
    localparam int MAX_BYTES      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } state_e;

    // Keeps are MSB-contiguous, so the number of set bits is the byte count.
    function automatic int keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int cnt, input int nbytes);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && i >= nbytes - cnt) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_hdr_inserter_mb_packer.sv
// Combinational byte packer: appends a keep-qualified beat behind an MSB-aligned residue
// and splits the result into one output beat plus a new residue.
module axis_byte_packer
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD    = DEF_DATA_WD,
    parameter int DATA_BYTES = DATA_WD / 8,
    parameter int CNT_WD     = $clog2(DATA_BYTES + 1)
) (
    input  logic [DATA_WD-1:0]    res_data_i,
    input  logic [CNT_WD-1:0]     res_cnt_i,
    input  logic [DATA_WD-1:0]    beat_data_i,
    input  logic [DATA_BYTES-1:0] beat_keep_i,
    output logic [DATA_WD-1:0]    out_data_o,
    output logic [DATA_BYTES-1:0] out_keep_o,
    output logic [DATA_WD-1:0]    res_data_o,
    output logic [CNT_WD-1:0]     res_cnt_o,
    output logic                  overflow_o
);

    logic [DATA_WD-1:0]   masked;
    logic [2*DATA_WD-1:0] wide;
    logic [MAX_BYTES-1:0] keep_w;
    int                   r;
    int                   total;

    always_comb begin
        masked = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (beat_keep_i[i]) masked[i*8 +: 8] = beat_data_i[i*8 +: 8];
        end
        r     = int'(res_cnt_i);
        total = r + keep_to_cnt(MAX_BYTES'(beat_keep_i));
        // Shift the beat so its first byte lands directly behind the r residue bytes.
        wide  = {res_data_i, {DATA_WD{1'b0}}}
              | ({{DATA_WD{1'b0}}, masked} << (8 * (DATA_BYTES - r)));
        out_data_o = wide[2*DATA_WD-1 -: DATA_WD];
        overflow_o = (total >= DATA_BYTES);
        if (overflow_o) begin
            keep_w     = cnt_to_keep(DATA_BYTES, DATA_BYTES);
            res_data_o = wide[DATA_WD-1:0];
            res_cnt_o  = CNT_WD'(total - DATA_BYTES);
        end else begin
            keep_w     = cnt_to_keep(total, DATA_BYTES);
            res_data_o = wide[2*DATA_WD-1 -: DATA_WD];
            res_cnt_o  = CNT_WD'(total);
        end
        out_keep_o = keep_w[DATA_BYTES-1:0];
    end

endmodule

// File: rtl/axis_hdr_inserter_mb.sv
// Multi-beat AXI-Stream header inserter with byte repacking.
// Optional packet/byte counters are built when AXIS_HDR_PKT_CNT_EN is defined.
module axis_hdr_inserter_mb
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD    = DEF_DATA_WD,
    parameter int DATA_BYTES = DATA_WD / 8,
    parameter int HDR_BYTES  = DEF_HDR_BYTES,
    parameter int HDR_CNT_WD = $clog2(HDR_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [DATA_WD-1:0]     s_data,
    input  logic [DATA_BYTES-1:0]  s_keep,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [DATA_WD-1:0]     m_data,
    output logic [DATA_BYTES-1:0]  m_keep,
    output logic                   m_last,
    input  logic                   m_ready,
    input  logic                   h_valid,
    input  logic [HDR_BYTES*8-1:0] h_data,
    input  logic [HDR_CNT_WD-1:0]  h_bytes,
    output logic                   h_ready,
    output logic [1:0]             dbg_state_o
`ifdef AXIS_HDR_PKT_CNT_EN
    ,
    output logic [31:0]            pkt_cnt,
    output logic [31:0]            byte_cnt
`endif
);

    localparam int CNT_WD = $clog2(DATA_BYTES + 1);
    localparam int HW     = HDR_BYTES * 8;

    // Handshakes: a beat moves on s_*, m_* or h_* exactly in a cycle where valid && ready
    // at the rising edge; valid never waits on ready, and m_* hold while m_valid && !m_ready.

    state_e                  state_q, state_d;
    logic [HW-1:0]           hdr_q, hdr_d, hdr_shift;
    logic [HDR_CNT_WD-1:0]   hcnt_q, hcnt_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CNT_WD-1:0]       rcnt_q, rcnt_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [DATA_WD-1:0]      m_data_q, m_data_d;
    logic [DATA_BYTES-1:0]   m_keep_q, m_keep_d;

    logic                    out_adv;
    logic [DATA_WD-1:0]      pk_out, pk_res;
    logic [DATA_BYTES-1:0]   pk_keep;
    logic [CNT_WD-1:0]       pk_rcnt;
    logic                    pk_ovf;
    logic [MAX_BYTES-1:0]    tail_keep_w;

    assign out_adv   = !m_valid_q || m_ready;
    assign hdr_shift = hdr_q << DATA_WD;

    axis_byte_packer #(
        .DATA_WD    (DATA_WD),
        .DATA_BYTES (DATA_BYTES),
        .CNT_WD     (CNT_WD)
    ) u_packer (
        .res_data_i  (res_q),
        .res_cnt_i   (rcnt_q),
        .beat_data_i (s_data),
        .beat_keep_i (s_keep),
        .out_data_o  (pk_out),
        .out_keep_o  (pk_keep),
        .res_data_o  (pk_res),
        .res_cnt_o   (pk_rcnt),
        .overflow_o  (pk_ovf)
    );

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        hcnt_d      = hcnt_q;
        res_d       = res_q;
        rcnt_d      = rcnt_q;
        m_valid_d   = out_adv ? 1'b0 : m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        h_ready     = 1'b0;
        s_ready     = 1'b0;
        tail_keep_w = cnt_to_keep(int'(rcnt_q), DATA_BYTES);
        case (state_q)
            IDLE: begin
                h_ready = rst_n;
                if (h_valid) begin
                    // Left-align the valid low bytes so the header always drains from the top.
                    hdr_d   = h_data << (8 * (HDR_BYTES - int'(h_bytes)));
                    hcnt_d  = h_bytes;
                    res_d   = '0;
                    rcnt_d  = '0;
                    state_d = (h_bytes == '0) ? BODY : HDR;
                end
            end
            HDR: begin
                if (int'(hcnt_q) < DATA_BYTES) begin
                    res_d   = hdr_q[HW-1 -: DATA_WD];
                    rcnt_d  = CNT_WD'(hcnt_q);
                    hcnt_d  = '0;
                    state_d = BODY;
                end else if (out_adv) begin
                    m_valid_d = 1'b1;
                    m_data_d  = hdr_q[HW-1 -: DATA_WD];
                    m_keep_d  = {DATA_BYTES{1'b1}};
                    m_last_d  = 1'b0;
                    hdr_d     = hdr_shift;
                    hcnt_d    = hcnt_q - HDR_CNT_WD'(DATA_BYTES);
                    if (int'(hcnt_q) - DATA_BYTES < DATA_BYTES) begin
                        res_d   = hdr_shift[HW-1 -: DATA_WD];
                        rcnt_d  = CNT_WD'(int'(hcnt_q) - DATA_BYTES);
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                s_ready = out_adv;
                if (s_valid && out_adv) begin
                    res_d  = pk_res;
                    rcnt_d = pk_rcnt;
                    if (pk_ovf) begin
                        m_valid_d = 1'b1;
                        m_data_d  = pk_out;
                        m_keep_d  = pk_keep;
                        m_last_d  = s_last && (pk_rcnt == '0);
                        if (s_last) state_d = (pk_rcnt == '0) ? IDLE : TAIL;
                    end else if (s_last) begin
                        m_valid_d = 1'b1;
                        m_data_d  = pk_out;
                        m_keep_d  = pk_keep;
                        m_last_d  = 1'b1;
                        res_d     = '0;
                        rcnt_d    = '0;
                        state_d   = IDLE;
                    end
                end
            end
            TAIL: begin
                if (out_adv) begin
                    m_valid_d = 1'b1;
                    m_data_d  = res_q;
                    m_keep_d  = tail_keep_w[DATA_BYTES-1:0];
                    m_last_d  = 1'b1;
                    res_d     = '0;
                    rcnt_d    = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            hcnt_q    <= '0;
            res_q     <= '0;
            rcnt_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hcnt_q    <= hcnt_d;
            res_q     <= res_d;
            rcnt_q    <= rcnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_data      = m_data_q;
    assign m_keep      = m_keep_q;
    assign dbg_state_o = state_q;

`ifdef AXIS_HDR_PKT_CNT_EN
    logic [31:0] pkt_cnt_q, byte_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else if (m_valid_q && m_ready) begin
            byte_cnt_q <= byte_cnt_q + 32'(keep_to_cnt(MAX_BYTES'(m_keep_q)));
            if (m_last_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign byte_cnt = byte_cnt_q;
`endif

    // Accepted body keeps must be nonzero, MSB-contiguous, and full on every non-last beat.
    logic [MAX_BYTES-1:0] s_keep_w, s_keep_norm;
    logic                 keep_ok;

    always_comb begin
        s_keep_w    = MAX_BYTES'(s_keep);
        s_keep_norm = cnt_to_keep(keep_to_cnt(s_keep_w), DATA_BYTES);
        keep_ok     = (s_keep != '0) && (s_keep_w == s_keep_norm) && (s_last || (&s_keep));
    end

    a_keep_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (s_valid && s_ready) |-> keep_ok);

endmodule

// File: tb/tb_axis_hdr_inserter_mb.sv
// Randomized bench for axis_hdr_inserter_mb: byte-stream reference model, output stall
// stability, directed header lengths and reset mid-packet.
module tb_axis_hdr_inserter_mb;

    localparam int DW  = 32;
    localparam int DB  = 4;
    localparam int HB  = 12;
    localparam int HCW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic [DB-1:0]   s_keep = '0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [DB-1:0]   m_keep;
    logic            m_last;
    logic            m_ready = 1'b0;
    logic            h_valid = 1'b0;
    logic [HB*8-1:0] h_data = '0;
    logic [HCW-1:0]  h_bytes = '0;
    logic            h_ready;
    logic [1:0]      dbg_state;
`ifdef AXIS_HDR_PKT_CNT_EN
    logic [31:0]     pkt_cnt;
    logic [31:0]     byte_cnt;
`endif

    always #5 clk = ~clk;

    axis_hdr_inserter_mb #(
        .DATA_WD    (DW),
        .DATA_BYTES (DB),
        .HDR_BYTES  (HB),
        .HDR_CNT_WD (HCW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_keep      (s_keep),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .h_valid     (h_valid),
        .h_data      (h_data),
        .h_bytes     (h_bytes),
        .h_ready     (h_ready),
        .dbg_state_o (dbg_state)
`ifdef AXIS_HDR_PKT_CNT_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .byte_cnt    (byte_cnt)
`endif
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          len_q[$];
    int          rem = 0;
    int          ready_pct = 100;
    int          sent_pkts = 0;
    int          sent_bytes = 0;
    logic [DW-1:0] pk_data[$];
    logic [DB-1:0] pk_keep[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Scoreboard: the output must be the packet byte stream cut into DB-byte beats.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DB-1:0] prev_keep;
    logic          prev_last;
    int            mon_n;
    logic [DW-1:0] mon_ed, mon_mask;
    logic [DB-1:0] mon_ek;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", m_valid, 1'b1);
                check_eq("stall_data", m_data, prev_data);
                check_eq("stall_keep", m_keep, prev_keep);
                check_eq("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (rem == 0) begin
                    if (len_q.size() == 0) check_eq("spurious_beat", len_q.size(), 1);
                    else rem = len_q.pop_front();
                end
                mon_n    = (rem < DB) ? rem : DB;
                mon_ek   = 4'hF << (DB - mon_n);
                mon_ed   = '0;
                mon_mask = '0;
                for (int j = 0; j < mon_n; j++) begin
                    if (exp_q.size() != 0) mon_ed[(DB-1-j)*8 +: 8] = exp_q.pop_front();
                    mon_mask[(DB-1-j)*8 +: 8] = 8'hFF;
                end
                check_eq("m_keep", m_keep, mon_ek);
                check_eq("m_last", m_last, (rem <= DB));
                check_eq("m_data", m_data & mon_mask, mon_ed);
                rem = rem - mon_n;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
            prev_last  = m_last;
        end
    end

    task automatic do_reset(input int cycles);
        rst_n   = 1'b0;
        h_valid = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        exp_q.delete();
        len_q.delete();
        rem        = 0;
        sent_pkts  = 0;
        sent_bytes = 0;
        tick();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_eq("rst_m_valid", m_valid, 1'b0);
            check_eq("rst_m_last", m_last, 1'b0);
            check_eq("rst_m_data", m_data, '0);
            check_eq("rst_m_keep", m_keep, '0);
            check_eq("rst_s_ready", s_ready, 1'b0);
            check_eq("rst_h_ready", h_ready, 1'b0);
            check_eq("rst_state", dbg_state, 2'd0);
`ifdef AXIS_HDR_PKT_CNT_EN
            check_eq("rst_pkt_cnt", pkt_cnt, 0);
            check_eq("rst_byte_cnt", byte_cnt, 0);
`endif
            tick();
        end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check_eq("no_beat_after_rst", m_valid, 1'b0);
        check_eq("idle_h_ready", h_ready, 1'b1);
        tick();
    endtask

    task automatic add_beat(input logic [DW-1:0] d, input logic [DB-1:0] k);
        pk_data.push_back(d);
        pk_keep.push_back(k);
    endtask

    // Drives one packet from pk_data/pk_keep; stop_after >= 0 abandons it before that beat.
    task automatic send_pkt(input int hb, input logic [HB*8-1:0] hd, input bit early,
                            input int gap_pct, input int stop_after);
        int  total;
        int  nb;
        int  cnt;
        bit  got;
        nb    = pk_data.size();
        total = hb;
        for (int i = hb - 1; i >= 0; i--) exp_q.push_back(hd[i*8 +: 8]);
        for (int b = 0; b < nb; b++) begin
            for (int i = DB - 1; i >= 0; i--) begin
                if (pk_keep[b][i]) begin
                    exp_q.push_back(pk_data[b][i*8 +: 8]);
                    total++;
                end
            end
        end
        len_q.push_back(total);
        sent_pkts++;
        sent_bytes += total;

        h_valid = 1'b1;
        h_data  = hd;
        h_bytes = HCW'(hb);
        if (early) begin
            s_valid = 1'b1;
            s_data  = pk_data[0];
            s_keep  = pk_keep[0];
            s_last  = (nb == 1);
        end
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 2000) begin
            @(negedge clk);
            if (early) check_eq("s_ready_before_hdr", s_ready, 1'b0);
            got = h_ready;
            tick();
            cnt++;
        end
        h_valid = 1'b0;
        if (!got) begin
            check_eq("hdr_timeout", got, 1'b1);
            s_valid = 1'b0;
            return;
        end

        for (int b = 0; b < nb; b++) begin
            if (!(b == 0 && early)) begin
                if ($urandom_range(0, 99) < gap_pct) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 2)) tick();
                end
                s_valid = 1'b1;
                s_data  = pk_data[b];
                s_keep  = pk_keep[b];
                s_last  = (b == nb - 1);
            end
            if (b == stop_after) begin
                s_valid = 1'b0;
                return;
            end
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 2000) begin
                @(negedge clk);
                check_eq("h_ready_in_pkt", h_ready, 1'b0);
                got = s_ready;
                tick();
                cnt++;
            end
            if (!got) begin
                check_eq("body_timeout", got, 1'b1);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || rem != 0) && cnt < 4000) begin
            tick();
            cnt++;
        end
        check_eq("drain_empty", exp_q.size() + len_q.size() + rem, 0);
        tick();
    endtask

    task automatic rand_pkt(input int nbeats, input bit full_last);
        int n;
        pk_data.delete();
        pk_keep.delete();
        for (int b = 0; b < nbeats; b++) begin
            n = (b == nbeats - 1 && !full_last) ? $urandom_range(1, DB) : DB;
            add_beat($urandom, 4'hF << (DB - n));
        end
    endtask

    initial begin
        do_reset(4);

`ifdef AXIS_HDR_PKT_CNT_EN
        for (int rep = 0; rep < 2; rep++) begin
            pk_data.delete();
            pk_keep.delete();
            add_beat(32'h11223344, 4'hF);
            add_beat(32'h55660000, 4'hC);
            send_pkt(2, 96'h0000_0000_0000_0000_0000_AABB, 1'b0, 0, -1);
        end
        drain();
        @(negedge clk);
        check_eq("pkt_cnt", pkt_cnt, sent_pkts);
        check_eq("byte_cnt", byte_cnt, sent_bytes);
        tick();
`endif

        // Directed: short header, empty header, header of exactly three beats, tail overflow.
        ready_pct = 100;
        pk_data.delete();
        pk_keep.delete();
        add_beat(32'h11223344, 4'hF);
        add_beat(32'h55660000, 4'hC);
        send_pkt(2, 96'h0000_0000_0000_0000_0000_AABB, 1'b0, 0, -1);
        drain();

        pk_data.delete();
        pk_keep.delete();
        add_beat(32'hDEADBEEF, 4'hF);
        add_beat(32'h01234567, 4'hF);
        add_beat(32'h89ABCDEF, 4'h8);
        send_pkt(0, '0, 1'b0, 0, -1);
        drain();

        pk_data.delete();
        pk_keep.delete();
        add_beat(32'hC0FFEE00, 4'hF);
        send_pkt(12, {$urandom, $urandom, $urandom}, 1'b0, 0, -1);
        drain();

        pk_data.delete();
        pk_keep.delete();
        add_beat(32'h0A0B0C0D, 4'hE);
        send_pkt(3, {$urandom, $urandom, $urandom}, 1'b0, 0, -1);
        drain();

        // Random traffic with back-pressure, body gaps, early body and a mid-packet reset.
        for (int p = 0; p < 1000; p++) begin
            if (p % 100 == 0) ready_pct = $urandom_range(30, 100);
            if (p == 500) begin
                drain();
                rand_pkt(3, 1'b1);
                send_pkt($urandom_range(0, HB), {$urandom, $urandom, $urandom}, 1'b0, 20,
                         $urandom_range(0, 2));
                repeat ($urandom_range(0, 3)) tick();
                do_reset(3);
            end
            rand_pkt($urandom_range(1, 4), 1'b0);
            send_pkt($urandom_range(0, HB), {$urandom, $urandom, $urandom},
                     ($urandom_range(0, 3) == 0), 30, -1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
